// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar sweep controller:
//   - estado_t : 4-bit state encoding, also exported on db_estado
//   - cmd_t    : bundle of datapath command strobes driven by the controller
//   - TIMEOUT_MEDIDA_DEFAULT : measurement watchdog length
//                              (50 ms at 50 MHz)
//   - decodifica() : Moore output decode, state -> commands
// -----------------------------------------------------------------------------
package sonar_pkg;

  localparam int TIMEOUT_MEDIDA_DEFAULT = 2_500_000;

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARA        = 4'h1,
    ST_ESPERA         = 4'h2,
    ST_MEDE           = 4'h3,
    ST_AGUARDA_MEDIDA = 4'h4,
    ST_TRANSMITE      = 4'h5,
    ST_AGUARDA_TX     = 4'h6,
    ST_PROXIMO        = 4'h7,
    ST_VERIFICA       = 4'h8,
    ST_GIRA           = 4'h9,
    ST_TIMEOUT        = 4'hF
  } estado_t;

  typedef struct packed {
    logic zera_timer;
    logic conta_timer;
    logic zera_posicao;
    logic conta_posicao;
    logic reset_servo;
    logic medir;
    logic zera_serial;
    logic conta_serial;
    logic partida_serial;
    logic fim_ciclo;
  } cmd_t;

  // Commands are a pure function of the state. Unlisted and illegal codes
  // (A-E) drive nothing, so a corrupted state register never fires a command.
  function automatic cmd_t decodifica(input estado_t estado);
    cmd_t c;
    c = '0;
    case (estado)
      ST_PREPARA: begin
        c.zera_timer   = 1'b1;
        c.zera_posicao = 1'b1;
        c.zera_serial  = 1'b1;
        c.reset_servo  = 1'b1;
      end
      ST_ESPERA: c.conta_timer = 1'b1;
      ST_MEDE: begin
        c.medir       = 1'b1;
        c.zera_serial = 1'b1;
      end
      ST_TRANSMITE: c.partida_serial = 1'b1;
      ST_PROXIMO:   c.conta_serial   = 1'b1;
      ST_GIRA: begin
        c.conta_posicao = 1'b1;
        c.zera_timer    = 1'b1;
        c.fim_ciclo     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sonar_uc_contador_m.sv
// -----------------------------------------------------------------------------
// contador_m
// Modulo-M up counter used as the measurement watchdog. It saturates at M-1
// instead of wrapping, so a long stall can never alias back to a small count.
// Ports:
//   clock_i  : system clock
//   reset_i  : asynchronous active-high reset, clears the count
//   zera_i   : synchronous clear (has priority over conta_i)
//   conta_i  : count enable
//   fim_o    : high while the count equals M-1
// -----------------------------------------------------------------------------
module contador_m #(
  parameter int M = 100,
  localparam int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (zera_i) begin
      cnt_q <= '0;
    end else if (conta_i && (cnt_q != ULTIMO)) begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign fim_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/sonar_uc.sv
// -----------------------------------------------------------------------------
// sonar_uc
// Control unit of the sonar sweep. For each servo angle: wait for the settle
// timer, trigger a distance measurement (guarded by a watchdog), send an
// 8-character frame over the serial link, then step the servo.
//
// state            | meaning
// -----------------+---------------------------------------------------------
// INICIAL     (0)  | idle, waiting for ligar
// PREPARA     (1)  | clear timer, position, serial index; reset servo
// ESPERA      (2)  | run settle timer until fim_timer
// MEDE        (3)  | fire medir, clear serial index and watchdog
// AGUARDA_MED (4)  | wait pronto_medida or watchdog expiry
// TRANSMITE   (5)  | start one serial character
// AGUARDA_TX  (6)  | wait pronto_serial
// PROXIMO     (7)  | advance serial character index
// VERIFICA    (8)  | frame done? -> GIRA, else next character
// GIRA        (9)  | step servo position, restart timer, pulse fim_ciclo
// TIMEOUT     (F)  | measurement lost; skip frame for this angle
//
// Ports:
//   clock, reset (async, active high), ligar (sweep enable level)
//   fim_timer, pronto_medida, pronto_serial, fim_transmissao : datapath status
//   zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo, medir,
//   zera_serial, conta_serial, partida_serial : datapath commands
//   fim_ciclo : one-cycle pulse per completed angle step
//   db_estado : current state code
// -----------------------------------------------------------------------------
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int TIMEOUT_MEDIDA = TIMEOUT_MEDIDA_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_timer,
  input  logic       pronto_medida,
  input  logic       pronto_serial,
  input  logic       fim_transmissao,
  output logic       zera_timer,
  output logic       conta_timer,
  output logic       zera_posicao,
  output logic       conta_posicao,
  output logic       reset_servo,
  output logic       medir,
  output logic       zera_serial,
  output logic       conta_serial,
  output logic       partida_serial,
  output logic       fim_ciclo,
  output logic [3:0] db_estado
);

  estado_t state_q;
  estado_t state_d;
  cmd_t    cmd;
  logic    wd_fim;

  contador_m #(
    .M(TIMEOUT_MEDIDA)
  ) u_watchdog (
    .clock_i (clock),
    .reset_i (reset),
    .zera_i  (state_q == ST_MEDE),
    .conta_i (state_q == ST_AGUARDA_MEDIDA),
    .fim_o   (wd_fim)
  );

  // Dropping ligar aborts from anywhere, including mid-frame.
  always_comb begin
    state_d = state_q;
    if (!ligar && (state_q != ST_INICIAL)) begin
      state_d = ST_INICIAL;
    end else begin
      case (state_q)
        ST_INICIAL:        if (ligar) state_d = ST_PREPARA;
        ST_PREPARA:        state_d = ST_ESPERA;
        ST_ESPERA:         if (fim_timer) state_d = ST_MEDE;
        ST_MEDE:           state_d = ST_AGUARDA_MEDIDA;
        // A measurement arriving on the expiry cycle is still accepted.
        ST_AGUARDA_MEDIDA: begin
          if (pronto_medida) state_d = ST_TRANSMITE;
          else if (wd_fim)   state_d = ST_TIMEOUT;
        end
        ST_TRANSMITE:      state_d = ST_AGUARDA_TX;
        ST_AGUARDA_TX:     if (pronto_serial) state_d = ST_PROXIMO;
        ST_PROXIMO:        state_d = ST_VERIFICA;
        ST_VERIFICA:       state_d = fim_transmissao ? ST_GIRA : ST_TRANSMITE;
        ST_GIRA:           state_d = ST_ESPERA;
        ST_TIMEOUT:        state_d = ST_GIRA;
        default:           state_d = ST_INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign cmd = decodifica(state_q);

  assign zera_timer     = cmd.zera_timer;
  assign conta_timer    = cmd.conta_timer;
  assign zera_posicao   = cmd.zera_posicao;
  assign conta_posicao  = cmd.conta_posicao;
  assign reset_servo    = cmd.reset_servo;
  assign medir          = cmd.medir;
  assign zera_serial    = cmd.zera_serial;
  assign conta_serial   = cmd.conta_serial;
  assign partida_serial = cmd.partida_serial;
  assign fim_ciclo      = cmd.fim_ciclo;
  assign db_estado      = state_q;

endmodule

// File: tb/tb_sonar_uc.sv
module tb_sonar_uc;

  logic clock = 1'b0;
  logic reset;
  logic ligar;
  logic fim_timer, pronto_medida, pronto_serial, fim_transmissao;
  logic zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo;
  logic medir, zera_serial, conta_serial, partida_serial, fim_ciclo;
  logic [3:0] db_estado;
  logic [9:0] outs;

  int errors = 0;
  int checks = 0;
  int n_partida = 0, n_conta_serial = 0, n_conta_pos = 0, n_fim_ciclo = 0;
  int b_partida, b_conta_serial, b_conta_pos, b_fim_ciclo;

  // {zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo,
  //  medir, zera_serial, conta_serial, partida_serial, fim_ciclo}
  localparam logic [9:0] O_NONE      = 10'b0000000000;
  localparam logic [9:0] O_PREPARA   = 10'b1010101000;
  localparam logic [9:0] O_ESPERA    = 10'b0100000000;
  localparam logic [9:0] O_MEDE      = 10'b0000011000;
  localparam logic [9:0] O_TRANSMITE = 10'b0000000010;
  localparam logic [9:0] O_PROXIMO   = 10'b0000000100;
  localparam logic [9:0] O_GIRA      = 10'b1001000001;

  assign outs = {zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo,
                 medir, zera_serial, conta_serial, partida_serial, fim_ciclo};

  sonar_uc #(.TIMEOUT_MEDIDA(20)) dut (
    .clock(clock), .reset(reset), .ligar(ligar),
    .fim_timer(fim_timer), .pronto_medida(pronto_medida),
    .pronto_serial(pronto_serial), .fim_transmissao(fim_transmissao),
    .zera_timer(zera_timer), .conta_timer(conta_timer),
    .zera_posicao(zera_posicao), .conta_posicao(conta_posicao),
    .reset_servo(reset_servo), .medir(medir), .zera_serial(zera_serial),
    .conta_serial(conta_serial), .partida_serial(partida_serial),
    .fim_ciclo(fim_ciclo), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Counts each cycle a strobe is high (value seen just before the edge).
  always @(posedge clock) begin
    if (!reset) begin
      n_partida      <= n_partida + int'(partida_serial);
      n_conta_serial <= n_conta_serial + int'(conta_serial);
      n_conta_pos    <= n_conta_pos + int'(conta_posicao);
      n_fim_ciclo    <= n_fim_ciclo + int'(fim_ciclo);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic snap();
    b_partida = n_partida;
    b_conta_serial = n_conta_serial;
    b_conta_pos = n_conta_pos;
    b_fim_ciclo = n_fim_ciclo;
  endtask

  // From ESPERA: one full angle with measurement after 'lat' waiting cycles
  // and an 8-character frame; returns observing ESPERA again.
  task automatic angulo(input int lat);
    fim_timer = 1'b1; step(); fim_timer = 1'b0;
    chk("ang_mede", db_estado, 4'h3);
    repeat (lat) step();
    pronto_medida = 1'b1; step(); pronto_medida = 1'b0;
    chk("ang_transmite", db_estado, 4'h5);
    for (int i = 0; i < 8; i++) begin
      step();
      pronto_serial = 1'b1; step(); pronto_serial = 1'b0;
      step();
      if (i == 7) fim_transmissao = 1'b1;
      step(); fim_transmissao = 1'b0;
    end
    chk("ang_gira", db_estado, 4'h9);
    step();
    chk("ang_espera", db_estado, 4'h2);
  endtask

  initial begin
    int n;
    reset = 1'b1; ligar = 1'b0;
    fim_timer = 1'b0; pronto_medida = 1'b0; pronto_serial = 1'b0; fim_transmissao = 1'b0;
    step(); step();
    chk("rst_estado", db_estado, 4'h0);
    chk("rst_outs", outs, O_NONE);
    ligar = 1'b1;
    step();
    chk("rst_outs_ligar", outs, O_NONE);
    reset = 1'b0;

    // Start-up: 0 -> 1 -> 2, clears for exactly one cycle.
    step();
    chk("prepara_estado", db_estado, 4'h1);
    chk("prepara_outs", outs, O_PREPARA);
    step();
    chk("espera_estado", db_estado, 4'h2);
    chk("espera_outs", outs, O_ESPERA);
    step();
    chk("espera_hold", db_estado, 4'h2);

    // Full angle, measurement 10 cycles after medir.
    snap();
    fim_timer = 1'b1; step(); fim_timer = 1'b0;
    chk("mede_estado", db_estado, 4'h3);
    chk("mede_outs", outs, O_MEDE);
    step();
    chk("aguarda_med", db_estado, 4'h4);
    chk("aguarda_med_outs", outs, O_NONE);
    repeat (8) step();
    pronto_medida = 1'b1; step(); pronto_medida = 1'b0;
    chk("transmite_estado", db_estado, 4'h5);
    chk("transmite_outs", outs, O_TRANSMITE);
    for (int i = 0; i < 8; i++) begin
      chk("frame_transmite", db_estado, 4'h5);
      step();
      chk("frame_aguarda_tx", db_estado, 4'h6);
      step();
      pronto_serial = 1'b1; step(); pronto_serial = 1'b0;
      chk("frame_proximo", db_estado, 4'h7);
      chk("frame_proximo_outs", outs, O_PROXIMO);
      step();
      chk("frame_verifica", db_estado, 4'h8);
      if (i == 7) fim_transmissao = 1'b1;
      step(); fim_transmissao = 1'b0;
    end
    chk("gira_estado", db_estado, 4'h9);
    chk("gira_outs", outs, O_GIRA);
    step();
    chk("pos_gira_espera", db_estado, 4'h2);
    chk("n_partida_frame", n_partida - b_partida, 8);
    chk("n_conta_serial_frame", n_conta_serial - b_conta_serial, 8);
    chk("n_conta_pos_frame", n_conta_pos - b_conta_pos, 1);
    chk("n_fim_ciclo_frame", n_fim_ciclo - b_fim_ciclo, 1);

    // Watchdog expiry: 20 cycles in AGUARDA_MEDIDA, then TIMEOUT, then GIRA.
    snap();
    fim_timer = 1'b1; step(); fim_timer = 1'b0;
    chk("to_mede", db_estado, 4'h3);
    step();
    n = 0;
    while (db_estado == 4'h4 && n < 100) begin
      n++;
      step();
    end
    chk("to_ciclos_aguarda", n, 20);
    chk("to_estado", db_estado, 4'hF);
    chk("to_outs", outs, O_NONE);
    step();
    chk("to_gira", db_estado, 4'h9);
    step();
    chk("to_espera", db_estado, 4'h2);
    chk("to_n_partida", n_partida - b_partida, 0);
    chk("to_n_fim_ciclo", n_fim_ciclo - b_fim_ciclo, 1);

    // pronto_medida on the expiry cycle wins.
    fim_timer = 1'b1; step(); fim_timer = 1'b0;
    chk("tie_mede", db_estado, 4'h3);
    step();
    repeat (19) step();
    chk("tie_aguarda", db_estado, 4'h4);
    pronto_medida = 1'b1; step(); pronto_medida = 1'b0;
    chk("tie_transmite", db_estado, 4'h5);

    // ligar dropped in AGUARDA_TX.
    step();
    chk("abort_aguarda_tx", db_estado, 4'h6);
    snap();
    ligar = 1'b0;
    step();
    chk("abort_estado", db_estado, 4'h0);
    chk("abort_outs", outs, O_NONE);
    pronto_serial = 1'b1; step(); pronto_serial = 1'b0;
    chk("abort_fica_inicial", db_estado, 4'h0);
    chk("abort_conta_serial", n_conta_serial - b_conta_serial, 0);

    // Async reset between edges, then an 8-angle sweep.
    ligar = 1'b1;
    step();
    chk("re_prepara", db_estado, 4'h1);
    step();
    fim_timer = 1'b1; step(); fim_timer = 1'b0;
    chk("re_mede", db_estado, 4'h3);
    #2 reset = 1'b1;
    #1;
    chk("async_estado", db_estado, 4'h0);
    chk("async_outs", outs, O_NONE);
    step();
    reset = 1'b0;
    step();
    chk("pos_reset_prepara", db_estado, 4'h1);
    step();
    chk("pos_reset_espera", db_estado, 4'h2);
    snap();
    for (int a = 0; a < 8; a++) angulo(2 + a);
    chk("sweep_fim_ciclo", n_fim_ciclo - b_fim_ciclo, 8);
    chk("sweep_conta_pos", n_conta_pos - b_conta_pos, 8);
    chk("sweep_partida", n_partida - b_partida, 64);
    chk("sweep_conta_serial", n_conta_serial - b_conta_serial, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonar_uc.md
SONAR_UC -- requirements
Module: sonar_uc

Interface
REQ-001 SHALL have parameter TIMEOUT_MEDIDA, default 2_500_000, the number of cycles to wait for pronto_medida after medir (50 ms at 50 MHz).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port ligar, input, 1, the level enable for the sonar sweep.
REQ-005 SHALL have inputs fim_timer, pronto_medida, pronto_serial and fim_transmissao, each 1 bit, as the status flags from the datapath.
REQ-006 SHALL have outputs zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo, medir, zera_serial, conta_serial and partida_serial, each 1 bit, as the datapath commands.
REQ-007 SHALL have output fim_ciclo, 1 bit, a one-cycle pulse issued per completed angle step.
REQ-008 SHALL have output db_estado, 4 bits, carrying the current state code.

Function
REQ-009 SHALL be a Moore FSM; every output SHALL decode from the state register only, except the watchdog compare.
REQ-010 SHALL use these state codes: INICIAL=0, PREPARA=1, ESPERA=2, MEDE=3, AGUARDA_MEDIDA=4, TRANSMITE=5, AGUARDA_TX=6, PROXIMO=7, VERIFICA=8, GIRA=9, TIMEOUT=F; codes A-E are illegal and SHALL go to INICIAL.
REQ-011 INICIAL SHALL go to PREPARA when ligar=1; no command is asserted in INICIAL.
REQ-012 PREPARA SHALL assert zera_timer, zera_posicao, zera_serial and reset_servo for one cycle, then go to ESPERA.
REQ-013 ESPERA SHALL assert conta_timer and go to MEDE on fim_timer=1.
REQ-014 MEDE SHALL assert medir and zera_serial for one cycle, clear the watchdog, then go to AGUARDA_MEDIDA.
REQ-015 AGUARDA_MEDIDA SHALL increment the watchdog each cycle; pronto_medida=1 SHALL go to TRANSMITE, and a watchdog count of TIMEOUT_MEDIDA-1 SHALL go to TIMEOUT.
REQ-016 When pronto_medida and watchdog expiry occur in the same cycle, pronto_medida SHALL win.
REQ-017 TIMEOUT SHALL last one cycle and go to GIRA, so no frame is transmitted for that angle.
REQ-018 TRANSMITE SHALL assert partida_serial for exactly one cycle, then go to AGUARDA_TX.
REQ-019 AGUARDA_TX SHALL go to PROXIMO on pronto_serial=1.
REQ-020 PROXIMO SHALL assert conta_serial for one cycle, then go to VERIFICA.
REQ-021 VERIFICA SHALL go to GIRA if fim_transmissao=1, else to TRANSMITE; a frame therefore holds 8 characters.
REQ-022 GIRA SHALL assert conta_posicao, zera_timer and fim_ciclo for one cycle, then go to ESPERA.
REQ-023 ligar=0 in any state other than INICIAL SHALL force INICIAL on the next edge, abandoning any transfer in progress.
REQ-024 The watchdog SHALL be ceil(log2(TIMEOUT_MEDIDA)) bits wide, SHALL saturate and not wrap, and SHALL count only in AGUARDA_MEDIDA.
REQ-025 Each command pulse SHALL be exactly one cycle wide per state visit; commands SHALL never overlap except as listed in REQ-012, REQ-014 and REQ-022.

Reset
REQ-026 Asserting reset SHALL immediately force INICIAL and clear the watchdog, without waiting for a clock edge.
REQ-027 While reset is asserted, all outputs SHALL be 0 and db_estado SHALL be 0000.
REQ-028 Releasing reset with ligar=1 SHALL enter PREPARA on the first clock edge.

Structure
REQ-029 The state codes and the TIMEOUT_MEDIDA default SHALL be defined in the shared package sonar_pkg.
REQ-030 The watchdog SHALL be a single contador_m instance with M=TIMEOUT_MEDIDA, cleared in MEDE and enabled in AGUARDA_MEDIDA; all other logic SHALL be inline.

Verification
REQ-031 Bench SHALL cover: reset, then ligar=1 -> db_estado goes 0->1->2, and PREPARA asserts all four clears for exactly one cycle.
REQ-032 Bench SHALL cover: fim_timer pulse, then pronto_medida 10 cycles after medir -> one partida_serial pulse, then 8 TRANSMITE visits with fim_transmissao asserted after the 8th conta_serial -> GIRA -> one conta_posicao and one fim_ciclo.
REQ-033 Bench SHALL cover: TIMEOUT_MEDIDA=20 with no pronto_medida -> TIMEOUT entered 20 cycles after MEDE, zero partida_serial pulses, then GIRA.
REQ-034 Bench SHALL cover: pronto_medida on the exact cycle of watchdog expiry -> TRANSMITE is entered, not TIMEOUT.
REQ-035 Bench SHALL cover: ligar dropped during AGUARDA_TX -> INICIAL on the next edge, all outputs 0, no conta_serial.
REQ-036 Bench SHALL cover: reset pulsed mid-cycle with no clock edge -> db_estado=0 and outputs 0 immediately, and a sweep of 8 angles runs cleanly afterwards.
